// File: rtl/btn_conditioner_pkg.sv
// Shared types and helpers for the button conditioner: channel indices, FSM state type,
// and counter-width helpers.
package btn_pkg;

    localparam int NUM_BTN    = 3;
    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_CENTER = 2;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        REPEAT,
        HELD
    } btn_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the game core.
// The conditioner sits on the slave side; the board or stimulus drives the master side.
interface btn_conditioner_if;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_conditioner_channel.sv
// One button channel: synchroniser, debounce filter and press/release/auto-repeat FSM.
// Auto-repeat (FIRST/REPEAT states, rcnt) is built only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DELAY        = 1000000,
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_FIRST = 30000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int REPEAT_EN    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int              CNT_W   = width_of(DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY);

    generate
        if (SYNC_STAGES < 2 || DELAY < 0 || REPEAT_FIRST < 1 || REPEAT_RATE < 1 ||
            REPEAT_EN < 0 || REPEAT_EN > 1) begin : g_bad_cfg
            $error("btn_channel: illegal parameter set");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise, fall;

    // A new value is accepted only after DELAY+1 consecutive cycles of disagreement.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Edge events are taken from the next-state level so pulses land on the same edge as the level.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    btn_state_t state_q, state_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int               RCNT_W  = width_of(max_of(REPEAT_FIRST, REPEAT_RATE));
    localparam logic [RCNT_W-1:0] RF_LAST = RCNT_W'(REPEAT_FIRST - 1);
    localparam logic [RCNT_W-1:0] RR_LAST = RCNT_W'(REPEAT_RATE - 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rcnt_d    = rcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = HELD;
`ifdef BTN_AUTOREPEAT_EN
                    rcnt_d  = '0;
                    if (REPEAT_EN != 0) begin
                        state_d = FIRST;
                    end
`endif
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            FIRST: begin
                if (fall) begin
                    release_d = 1'b1;
                    rcnt_d    = '0;
                    state_d   = IDLE;
                end else if (rcnt_q == RF_LAST) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    state_d = REPEAT;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            REPEAT: begin
                // A release due this cycle wins over a repeat pulse.
                if (fall) begin
                    release_d = 1'b1;
                    rcnt_d    = '0;
                    state_d   = IDLE;
                end else if (rcnt_q == RR_LAST) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
`endif
            HELD: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Three-button input conditioner (left, right, centre) feeding the game core.
// Auto-repeat on held buttons is built only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int         DELAY        = 1000000,
    parameter int         SYNC_STAGES  = 2,
    parameter int         REPEAT_FIRST = 30000000,
    parameter int         REPEAT_RATE  = 10000000,
    parameter logic [2:0] REPEAT_MASK  = 3'b011
) (
    input logic               clk,
    input logic               rst,
    btn_conditioner_if.slave  bus
);

    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] release_w;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            // The centre (fire) button never auto-repeats, whatever the mask says.
            btn_channel #(
                .DELAY        (DELAY),
                .SYNC_STAGES  (SYNC_STAGES),
                .REPEAT_FIRST (REPEAT_FIRST),
                .REPEAT_RATE  (REPEAT_RATE),
                .REPEAT_EN    ((gi != BTN_CENTER) ? int'(REPEAT_MASK[gi]) : 0)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .raw_i     (bus.btn_raw[gi]),
                .level_o   (level_w[gi]),
                .press_o   (press_w[gi]),
                .release_o (release_w[gi])
            );
        end
    endgenerate

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;

endmodule
